z80_bus_responder: RTL and testbench

Synchronous bus-slave model for the CPU pin interface: it answers memory, I/O and interrupt-acknowledge cycles issued by the CPU. It sits on the test-bench side of the pin interface and replaces ad-hoc bench memory. It also generates `nINT`/`nNMI` requests and inserts programmable wait states. It backs a small RAM, one I/O register and a host preload port for program images.

---
 rtl/z80_bus_responder.sv | 209 ++++++++++++++++++++
 tb/tb_z80_bus_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_responder.sv
// Bus-slave model answering Z80 memory, I/O and interrupt-acknowledge cycles, with RAM, a port register and a preload port.
// Define Z80_RESP_WAIT_EN to compile in the wait-state counter, the WAIT state and the nWAIT drive.
module z80_bus_responder #(
  parameter int          MEM_AW      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  IO_PORT     = 8'hFE,
  parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
  input  logic              CPUCLK,
  input  logic              nRESET,
  input  logic              nM1,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nRFSH,
  input  logic [15:0]       A,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  output logic              nWAIT,
  output logic              nINT,
  output logic              nNMI,
  input  logic              irq_trig,
  input  logic              nmi_trig,
  input  logic              load_we,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [7:0]        io_reg
);

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
`ifdef Z80_RESP_WAIT_EN
    , ST_WAIT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic [7:0]  io_reg_q, io_reg_d;
  logic        pending_q, pending_d;
  logic [1:0]  nmi_cnt_q, nmi_cnt_d;
  logic        nnmi_q, nnmi_d;
`ifdef Z80_RESP_WAIT_EN
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        nwait_q, nwait_d;
  logic        is_inta_q, is_inta_d;
`else
  logic        unused_cfg;
`endif

  logic [7:0]        mem [2**MEM_AW];
  logic [MEM_AW-1:0] mem_addr;
  logic              cyc_inta, cyc_mrd, cyc_iord, cyc_mwr, cyc_iowr;
  logic              port_hit, inta_hit, cpu_mem_we;
  logic [7:0]        rd_byte;
  logic              unused_addr;

  assign mem_addr    = A[MEM_AW-1:0];
  assign unused_addr = ^A[15:MEM_AW];
  assign port_hit    = (A[7:0] == IO_PORT);

  // Refresh cycles also pull nMREQ low; nRFSH keeps them out of the memory decode.
  assign cyc_inta = !nM1 && !nIORQ;
  assign cyc_mrd  = !nMREQ && !nRD && nRFSH;
  assign cyc_iord = !nIORQ && !nRD && nM1;
  assign cyc_mwr  = !nMREQ && !nWR && nRFSH;
  assign cyc_iowr = !nIORQ && !nWR;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    dout_d     = dout_q;
    doe_d      = doe_q;
    io_reg_d   = io_reg_q;
    cpu_mem_we = 1'b0;
    inta_hit   = 1'b0;
`ifdef Z80_RESP_WAIT_EN
    wait_cnt_d = wait_cnt_q;
    nwait_d    = nwait_q;
    is_inta_d  = is_inta_q;
`endif

    if (cyc_inta)     rd_byte = INT_VECTOR;
    else if (cyc_mrd) rd_byte = mem[mem_addr];
    else if (port_hit) rd_byte = io_reg_q;
    else              rd_byte = 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (cyc_inta || cyc_mrd || cyc_iord) begin
          inta_hit = cyc_inta;
          dout_d   = rd_byte;
`ifdef Z80_RESP_WAIT_EN
          if (WAIT_LOAD != 3'd0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
            nwait_d    = 1'b0;
            is_inta_d  = cyc_inta;
          end else begin
            state_d = ST_DRIVE;
            doe_d   = 1'b1;
          end
`else
          state_d = ST_DRIVE;
          doe_d   = 1'b1;
`endif
        end else if (cyc_mwr) begin
          state_d    = ST_HOLD;
          cpu_mem_we = 1'b1;
        end else if (cyc_iowr) begin
          state_d = ST_HOLD;
          if (port_hit) io_reg_d = D_in;
        end
      end
`ifdef Z80_RESP_WAIT_EN
      ST_WAIT: begin
        // An acknowledge has no nRD, so its abort is signalled by nIORQ instead.
        if (is_inta_q ? nIORQ : nRD) begin
          state_d    = ST_IDLE;
          nwait_d    = 1'b1;
          wait_cnt_d = 3'd0;
        end else if (wait_cnt_q <= 3'd1) begin
          state_d    = ST_DRIVE;
          doe_d      = 1'b1;
          nwait_d    = 1'b1;
          wait_cnt_d = 3'd0;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
`endif
      ST_DRIVE: begin
        if (nRD && nIORQ) begin
          state_d = ST_IDLE;
          doe_d   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (nWR && nMREQ && nIORQ) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh request on the acknowledge edge wins over the clear.
    pending_d = irq_trig || (pending_q && !inta_hit);

    if (nmi_trig)               nmi_cnt_d = 2'd2;
    else if (nmi_cnt_q != 2'd0) nmi_cnt_d = nmi_cnt_q - 2'd1;
    else                        nmi_cnt_d = 2'd0;
    nnmi_d = (nmi_cnt_d == 2'd0);
  end

  always_ff @(posedge CPUCLK or negedge nRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      dout_q     <= 8'h00;
      doe_q      <= 1'b0;
      io_reg_q   <= 8'h00;
      pending_q  <= 1'b0;
      nmi_cnt_q  <= 2'd0;
      nnmi_q     <= 1'b1;
`ifdef Z80_RESP_WAIT_EN
      wait_cnt_q <= 3'd0;
      nwait_q    <= 1'b1;
      is_inta_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      io_reg_q   <= io_reg_d;
      pending_q  <= pending_d;
      nmi_cnt_q  <= nmi_cnt_d;
      nnmi_q     <= nnmi_d;
`ifdef Z80_RESP_WAIT_EN
      wait_cnt_q <= wait_cnt_d;
      nwait_q    <= nwait_d;
      is_inta_q  <= is_inta_d;
`endif
    end
  end

  // NOTE: the RAM array has no reset; clearing it would force a flop array instead of a memory.
  always_ff @(posedge CPUCLK) begin
    if (cpu_mem_we)   mem[mem_addr]  <= D_in;
    else if (load_we) mem[load_addr] <= load_data;
  end

  assign D_out  = dout_q;
  assign D_oe   = doe_q;
  assign nINT   = !pending_q;
  assign nNMI   = nnmi_q;
  assign io_reg = io_reg_q;
`ifdef Z80_RESP_WAIT_EN
  assign nWAIT  = nwait_q;
`else
  assign nWAIT      = 1'b1;
  assign unused_cfg = ^WAIT_LOAD;
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: one instance with 1 wait state, one with 5 sharing the same bus.
// Expected timing follows the Z80_RESP_WAIT_EN setting used for the build.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        n_m1 = 1'b1, n_mreq = 1'b1, n_iorq = 1'b1, n_rd = 1'b1, n_wr = 1'b1, n_rfsh = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        irq_trig = 1'b0, nmi_trig = 1'b0, load_we = 1'b0;
  logic [9:0]  load_addr = 10'h000;
  logic [7:0]  load_data = 8'h00;

  logic [7:0]  d_out, io_reg, d_out5, io_reg5;
  logic        d_oe, n_wait, n_int, n_nmi;
  logic        d_oe5, n_wait5, n_int5, n_nmi5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  z80_bus_responder #(.MEM_AW(10), .WAIT_CYCLES(1), .IO_PORT(8'hFE), .INT_VECTOR(8'hFF)) dut (
    .CPUCLK(clk), .nRESET(n_reset), .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq),
    .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .A(a), .D_in(d_in),
    .D_out(d_out), .D_oe(d_oe), .nWAIT(n_wait), .nINT(n_int), .nNMI(n_nmi),
    .irq_trig(irq_trig), .nmi_trig(nmi_trig), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .io_reg(io_reg)
  );

  z80_bus_responder #(.MEM_AW(10), .WAIT_CYCLES(5), .IO_PORT(8'hFE), .INT_VECTOR(8'hFF)) dut5 (
    .CPUCLK(clk), .nRESET(n_reset), .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq),
    .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .A(a), .D_in(d_in),
    .D_out(d_out5), .D_oe(d_oe5), .nWAIT(n_wait5), .nINT(n_int5), .nNMI(n_nmi5),
    .irq_trig(irq_trig), .nmi_trig(nmi_trig), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .io_reg(io_reg5)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = 6'b111111;
  endtask

  // Called right after the decode edge of a read-type cycle on the 1-wait instance.
  task automatic finish_read(input string tag, input logic [7:0] exp);
`ifdef Z80_RESP_WAIT_EN
    check({tag, " nwait_low"}, {7'd0, n_wait}, 8'd0);
    check({tag, " doe_early"}, {7'd0, d_oe}, 8'd0);
    step();
`endif
    check({tag, " doe"}, {7'd0, d_oe}, 8'd1);
    check({tag, " nwait_up"}, {7'd0, n_wait}, 8'd1);
    check({tag, " data"}, d_out, exp);
    bus_idle();
    step();
    check({tag, " doe_off"}, {7'd0, d_oe}, 8'd0);
  endtask

  task automatic mem_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    a = addr; n_mreq = 1'b0; n_rd = 1'b0;
    step();
    finish_read(tag, exp);
  endtask

  task automatic io_read(input string tag, input logic [7:0] port, input logic [7:0] exp);
    a = {8'h00, port}; n_iorq = 1'b0; n_rd = 1'b0;
    step();
    finish_read(tag, exp);
  endtask

  task automatic mem_write(input logic [15:0] addr, input logic [7:0] data);
    a = addr; d_in = data; n_mreq = 1'b0; n_wr = 1'b0;
    step();
    step();
    bus_idle();
    step();
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    a = {8'h00, port}; d_in = data; n_iorq = 1'b0; n_wr = 1'b0;
    step();
    step();
    bus_idle();
    step();
  endtask

  initial begin
    // Reset held with random strobe activity.
    for (int i = 0; i < 4; i++) begin
      {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = 6'($urandom);
      a = 16'($urandom);
      step();
    end
    check("rst doe", {7'd0, d_oe}, 8'd0);
    check("rst nwait", {7'd0, n_wait}, 8'd1);
    check("rst nint", {7'd0, n_int}, 8'd1);
    check("rst nnmi", {7'd0, n_nmi}, 8'd1);
    check("rst io_reg", io_reg, 8'h00);
    check("rst dout", d_out, 8'h00);
    bus_idle();
    @(negedge clk) n_reset = 1'b1;
    step();
    step();
    check("post_rst doe", {7'd0, d_oe}, 8'd0);
    check("post_rst nwait", {7'd0, n_wait}, 8'd1);
    check("post_rst nint", {7'd0, n_int}, 8'd1);

    // Preload, then CPU write over it, then read through the mirror.
    load_we = 1'b1; load_addr = 10'h005; load_data = 8'h3E;
    step();
    load_we = 1'b0;
    mem_read("preload", 16'h0005, 8'h3E);
    mem_write(16'h0005, 8'hA5);
    mem_read("mirror", 16'h0405, 8'hA5);

    // I/O port register.
    io_write(8'hFE, 8'h5A);
    check("iowr hit", io_reg, 8'h5A);
    io_read("iord hit", 8'hFE, 8'h5A);
    io_read("iord miss", 8'h10, 8'hFF);
    io_write(8'h10, 8'h77);
    check("iowr miss", io_reg, 8'h5A);

    // Interrupt request and acknowledge.
    irq_trig = 1'b1;
    step();
    irq_trig = 1'b0;
    check("irq nint", {7'd0, n_int}, 8'd0);
    n_m1 = 1'b0; n_iorq = 1'b0;
    step();
    check("inta nint", {7'd0, n_int}, 8'd1);
    finish_read("inta", 8'hFF);
    irq_trig = 1'b1;
    step();
    irq_trig = 1'b0;
    check("irq2 nint", {7'd0, n_int}, 8'd0);
    n_m1 = 1'b0; n_iorq = 1'b0; irq_trig = 1'b1;
    step();
    irq_trig = 1'b0;
    check("inta+irq nint", {7'd0, n_int}, 8'd0);
    finish_read("inta2", 8'hFF);
    check("inta2 nint_held", {7'd0, n_int}, 8'd0);

    // Read abandoned during wait states on the 5-wait instance.
    a = 16'h0005; n_mreq = 1'b0; n_rd = 1'b0;
    step();
`ifdef Z80_RESP_WAIT_EN
    check("abort nwait5 e0", {7'd0, n_wait5}, 8'd0);
    check("abort doe5 e0", {7'd0, d_oe5}, 8'd0);
    step();
    check("abort nwait5 e1", {7'd0, n_wait5}, 8'd0);
    check("abort doe5 e1", {7'd0, d_oe5}, 8'd0);
    bus_idle();
    step();
    check("abort nwait5 rel", {7'd0, n_wait5}, 8'd1);
    check("abort doe5 rel", {7'd0, d_oe5}, 8'd0);
    step();
    check("abort doe5 after", {7'd0, d_oe5}, 8'd0);
`else
    check("nowait doe5", {7'd0, d_oe5}, 8'd1);
    check("nowait data5", d_out5, 8'hA5);
    check("nowait nwait5", {7'd0, n_wait5}, 8'd1);
    bus_idle();
    step();
    check("nowait doe5 off", {7'd0, d_oe5}, 8'd0);
`endif

    // Asynchronous reset while driving the bus.
    a = 16'h0005; n_mreq = 1'b0; n_rd = 1'b0;
    step();
`ifdef Z80_RESP_WAIT_EN
    step();
`endif
    check("drive before rst", {7'd0, d_oe}, 8'd1);
    #2 n_reset = 1'b0;
    #1;
    check("async rst doe", {7'd0, d_oe}, 8'd0);
    check("async rst nwait", {7'd0, n_wait}, 8'd1);
    check("async rst io_reg", io_reg, 8'h00);
    bus_idle();
    @(negedge clk) n_reset = 1'b1;
    step();

    // NMI pulse width, then a retrigger inside the pulse.
    nmi_trig = 1'b1;
    step();
    nmi_trig = 1'b0;
    check("nmi c1", {7'd0, n_nmi}, 8'd0);
    step();
    check("nmi c2", {7'd0, n_nmi}, 8'd0);
    step();
    check("nmi end", {7'd0, n_nmi}, 8'd1);
    nmi_trig = 1'b1;
    step();
    nmi_trig = 1'b0;
    step();
    nmi_trig = 1'b1;
    step();
    nmi_trig = 1'b0;
    check("nmi re c1", {7'd0, n_nmi}, 8'd0);
    step();
    check("nmi re c2", {7'd0, n_nmi}, 8'd0);
    step();
    check("nmi re end", {7'd0, n_nmi}, 8'd1);

    // Preload colliding with a CPU write: the CPU write wins.
    a = 16'h0010; d_in = 8'h22; n_mreq = 1'b0; n_wr = 1'b0;
    load_we = 1'b1; load_addr = 10'h010; load_data = 8'h11;
    step();
    load_we = 1'b0;
    step();
    bus_idle();
    step();
    mem_read("collide", 16'h0010, 8'h22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
